servo_pos_seq: RTL and testbench
================================

SERVO_POS_SEQ -- requirements
Module: servo_pos_seq

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000000, clk cycles per servo frame (20 ms at 50 MHz); legal range 2 to 2^20.
REQ-002 Parameter SWEEP_FRAMES, default 50, frames per sweep step; legal range 1 to 255.
REQ-003 Parameter DEFAULT_POS, default 2'b00, pos value after reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_pos  input  2  target position code for the pwm block.
REQ-009 cmd_hold  input  8  frames to hold cmd_pos.
REQ-010 sweep_en  input  1  enables autonomous sweep while no command is pending.
REQ-011 pos  output  2  registered position, drives pwm.pos.
REQ-012 frame_tick  output  1  one-cycle pulse at the end of each frame.
REQ-013 cmd_done  output  1  one-cycle pulse when a command's hold completes.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 The frame counter SHALL run 0..FRAME_CYCLES-1 and wrap; frame_tick SHALL be high exactly in the cycle the counter equals FRAME_CYCLES-1.
REQ-016 The command FIFO SHALL hold 4 entries of {cmd_pos, cmd_hold}, in order; cmd_ready = !full.
REQ-017 When full, a push SHALL be refused even if a pop occurs in the same cycle; when not full, simultaneous push and pop SHALL both take effect.
REQ-018 States SHALL be IDLE, LOAD, HOLD, SWEEP.
REQ-019 IDLE: FIFO non-empty -> LOAD; else sweep_en -> SWEEP; else stay, pos unchanged.
REQ-020 LOAD (exactly 1 cycle): pos <= head.cmd_pos, hold_cnt <= max(head.cmd_hold,1), pop FIFO, -> HOLD.
REQ-021 HOLD: on frame_tick decrement hold_cnt; on frame_tick with hold_cnt==1 pulse cmd_done and -> IDLE in the same edge; the partial frame in progress at entry counts as the first frame.
REQ-022 cmd_hold==0 SHALL behave as cmd_hold==1.
REQ-023 Commands SHALL not preempt each other; a queued command starts only after the current HOLD exits (IDLE then LOAD, 2 cycles).
REQ-024 SWEEP: step counter counts frame_ticks; on the SWEEP_FRAMES-th tick pos steps one code and the counter clears.
REQ-025 Sweep order SHALL be triangular: 00,01,10,11,10,01,00,01...; direction flips on reaching 11 or 00; no wrap 11->00.
REQ-026 SWEEP with FIFO non-empty SHALL go to LOAD next cycle, discarding the step count but keeping sweep direction.
REQ-027 SWEEP with sweep_en low and FIFO empty SHALL go to IDLE next cycle, pos held.
REQ-028 Re-entering SWEEP SHALL start from the current pos with the step counter at 0.
REQ-029 pos SHALL only change in LOAD or on a sweep step; it SHALL be glitch-free (registered).

Reset
REQ-030 While rst_n low: state IDLE, pos=DEFAULT_POS, FIFO empty, cmd_ready=1, frame counter 0, hold_cnt 0, step counter 0, direction up, frame_tick=0, cmd_done=0, busy=0.
REQ-031 Reset mid-HOLD or mid-SWEEP SHALL discard queued commands; no cmd_done pulse is issued for the aborted command.
REQ-032 After rst_n rises, the first frame_tick SHALL occur FRAME_CYCLES cycles later.

Verification (FRAME_CYCLES=10, SWEEP_FRAMES=2)
REQ-033 Reset release, no stimulus -> pos=00, busy=0, cmd_ready=1, frame_tick every 10 cycles starting cycle 10.
REQ-034 Push {10,3} in IDLE -> LOAD next cycle, pos=10 one cycle later, cmd_done on the 3rd frame_tick, then busy=0, pos stays 10.
REQ-035 Push 5 commands back-to-back in HOLD -> cmd_ready low after 4th, 5th waits; all 4 applied in order, one cmd_done each.
REQ-036 sweep_en=1, empty FIFO -> pos 00,01,10,11,10,01,00 changing every 2nd frame_tick.
REQ-037 Push {11,0} during SWEEP -> LOAD next cycle, pos=11 for one frame, cmd_done, then sweep resumes from 11 stepping down.
REQ-038 Assert rst_n low mid-HOLD with 2 queued -> pos=00, FIFO empty, no cmd_done, busy=0 immediately.

Source files
------------

// File: rtl/servo_pos_seq_if.sv
// ---------------------------------------------------------------------------
// servo_pos_seq_if
// Command handshake between a command source and servo_pos_seq.
//
//   cmd_valid  source -> seq   command offered this cycle
//   cmd_ready  seq -> source   command queue can take an entry
//   cmd_pos    source -> seq   target position code (2 bits)
//   cmd_hold   source -> seq   number of frames to hold cmd_pos (8 bits)
//
// A command transfers on any rising clock edge where cmd_valid && cmd_ready.
// ---------------------------------------------------------------------------
interface servo_pos_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_pos;
  logic [7:0] cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_pos,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pos,
    input  cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/servo_pos_seq.sv
// ---------------------------------------------------------------------------
// servo_pos_seq
// Position sequencer for a hobby-servo PWM block. Generates the servo frame
// timebase, queues position commands (4 deep) and either holds each command
// for a number of frames or, when idle with sweep enabled, sweeps the
// position code triangularly 00,01,10,11,10,01,00,...
//
// Parameters
//   FRAME_CYCLES  clk cycles per servo frame (2 .. 2^20)
//   SWEEP_FRAMES  frames per sweep step (1 .. 255)
//   DEFAULT_POS   position code after reset
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cmd         command handshake (slave side of servo_pos_seq_if)
//   sweep_en    allow autonomous sweep while no command is queued
//   pos         registered position code for the PWM block
//   frame_tick  one-cycle pulse in the last cycle of every frame
//   cmd_done    one-cycle pulse when a command's hold period ends
//   busy        sequencer is not in IDLE
// ---------------------------------------------------------------------------
module servo_pos_seq #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned SWEEP_FRAMES = 50,
  parameter logic [1:0]  DEFAULT_POS  = 2'b00
) (
  input  logic            clk,
  input  logic            rst_n,
  servo_pos_seq_if.slave  cmd,
  input  logic            sweep_en,
  output logic [1:0]      pos,
  output logic            frame_tick,
  output logic            cmd_done,
  output logic            busy
);

  // 20 bits covers the largest legal terminal count (2^20 - 1).
  localparam int unsigned     FC_W       = 20;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_CYCLES - 1);
  localparam logic [7:0]      STEP_LAST  = 8'(SWEEP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    SWEEP = 2'd3
  } state_t;

  // A zero hold is treated as a single frame.
  function automatic logic [7:0] hold_frames(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

  // Direction to use for the next sweep step from position p. The end codes
  // force a turn-around so a position loaded by a command (e.g. 11 while the
  // stored direction is up) never wraps 11->00 or 00->11.
  function automatic logic sweep_up(input logic [1:0] p, input logic d);
    if (p == 2'b11)      return 1'b0;
    else if (p == 2'b00) return 1'b1;
    else                 return d;
  endfunction

  state_t          state;
  logic [FC_W-1:0] frame_cnt;
  logic [7:0]      hold_cnt;
  logic [7:0]      step_cnt;
  logic            dir_up;

  // command FIFO
  logic [1:0] fifo_pos  [4];
  logic [7:0] fifo_hold [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  logic       step_dir;
  logic [1:0] step_pos;

  // ---- frame timebase ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  assign frame_tick = (frame_cnt == FRAME_LAST);

  // ---- command FIFO ----
  // cmd_ready depends only on the registered fill level, so a push is
  // refused while full even when LOAD pops in the same cycle.
  assign fifo_full     = (fifo_cnt == 3'd4);
  assign fifo_empty    = (fifo_cnt == 3'd0);
  assign cmd.cmd_ready = !fifo_full;
  assign push          = cmd.cmd_valid && !fifo_full;
  assign pop           = (state == LOAD);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pos[wr_ptr]  <= cmd.cmd_pos;
      fifo_hold[wr_ptr] <= cmd.cmd_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---- sequencer ----
  assign step_dir = sweep_up(pos, dir_up);
  assign step_pos = step_dir ? (pos + 2'd1) : (pos - 2'd1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pos      <= DEFAULT_POS;
      hold_cnt <= 8'd0;
      step_cnt <= 8'd0;
      dir_up   <= 1'b1;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= LOAD;
          end else if (sweep_en) begin
            step_cnt <= 8'd0;
            state    <= SWEEP;
          end
        end

        LOAD: begin
          pos      <= fifo_pos[rd_ptr];
          hold_cnt <= hold_frames(fifo_hold[rd_ptr]);
          state    <= HOLD;
        end

        // The frame already running when HOLD is entered is the first one.
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == 8'd1) begin
              hold_cnt <= 8'd0;
              cmd_done <= 1'b1;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
        end

        // A queued command wins over sweeping; direction is kept so the
        // sweep continues sensibly from wherever the command leaves pos.
        SWEEP: begin
          if (!fifo_empty) begin
            step_cnt <= 8'd0;
            state    <= LOAD;
          end else if (!sweep_en) begin
            step_cnt <= 8'd0;
            state    <= IDLE;
          end else if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= 8'd0;
              pos      <= step_pos;
              dir_up   <= sweep_up(step_pos, step_dir);
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pos_seq.sv
// ---------------------------------------------------------------------------
// tb_servo_pos_seq
// Directed bench for servo_pos_seq with FRAME_CYCLES=10, SWEEP_FRAMES=2.
// Stimulus pushes the expected output events into a scoreboard queue; a
// monitor on the falling edge pops an entry whenever pos changes or cmd_done
// pulses and compares pos, cmd_done, busy and the number of frame_ticks seen
// since the previous event.
// Cycle numbering: reset is released on a falling edge; "edge k" is the k-th
// rising edge after that, and the frame counter holds k mod 10 after it.
// ---------------------------------------------------------------------------
module tb_servo_pos_seq;
  localparam int FC = 10;
  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sweep_en = 1'b0;
  logic [1:0] pos;
  logic       frame_tick;
  logic       cmd_done;
  logic       busy;

  servo_pos_seq_if bus ();

  servo_pos_seq #(
    .FRAME_CYCLES(FC),
    .SWEEP_FRAMES(SF),
    .DEFAULT_POS (2'b00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (bus),
    .sweep_en  (sweep_en),
    .pos       (pos),
    .frame_tick(frame_tick),
    .cmd_done  (cmd_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [1:0] pos;
    logic       done;
    logic       busy;
    int         ticks;
  } ev_t;

  ev_t sb[$];

  function automatic void expect_ev(input string name, input logic [1:0] p,
                                    input logic d, input logic b, input int t);
    ev_t e;
    e.name = name; e.pos = p; e.done = d; e.busy = b; e.ticks = t;
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---- monitor ----
  logic [1:0] last_pos = 2'b00;
  int         ticks = 0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst_n) begin
      last_pos = pos;
      ticks    = 0;
    end else begin
      if (pos !== last_pos || cmd_done === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: pos=%0d cmd_done=%0d busy=%0d ticks=%0d",
                   pos, cmd_done, busy, ticks);
        end else begin
          e = sb.pop_front();
          if (pos !== e.pos || cmd_done !== e.done || busy !== e.busy || ticks != e.ticks) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d done=%0d busy=%0d ticks=%0d, expected pos=%0d done=%0d busy=%0d ticks=%0d",
                     e.name, pos, cmd_done, busy, ticks, e.pos, e.done, e.busy, e.ticks);
          end
        end
        last_pos = pos;
        ticks    = 0;
      end
      if (frame_tick === 1'b1) ticks++;
    end
  end

  // ---- stimulus helpers ----
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge where rst_n was released.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    sweep_en      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers a command from a falling edge and returns on the falling edge
  // after the rising edge that accepted it; cmd_valid is left high so the
  // caller can chain pushes back-to-back.
  task automatic push(input logic [1:0] p, input logic [7:0] h);
    int w;
    w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_pos   = p;
    bus.cmd_hold  = h;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: cmd_ready=%0d after %0d cycles, expected 1", bus.cmd_ready, w);
      bus.cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int first_tick;
    int second_tick;
    int nticks;

    bus.cmd_valid = 1'b0;
    bus.cmd_pos   = 2'b00;
    bus.cmd_hold  = 8'd0;

    // ---- reset state and frame timebase ----
    repeat (2) @(negedge clk);
    check("rst_pos", pos, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_cmd_done", cmd_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    first_tick  = -1;
    second_tick = -1;
    nticks      = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        nticks++;
        if (first_tick < 0) first_tick = i;
        else if (second_tick < 0) second_tick = i;
      end
    end
    // Counter reaches 9 after edge 9: the 10th cycle after release.
    check("first_tick_cycle", first_tick, 9);
    check("second_tick_cycle", second_tick, 19);
    check("tick_count_25cyc", nticks, 2);
    check("idle_pos", pos, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // ---- single command {10,3} from IDLE ----
    do_reset();
    expect_ev("t2_load", 2'b10, 1'b0, 1'b1, 0);
    expect_ev("t2_done", 2'b10, 1'b1, 1'b0, 3);
    cycles(1);
    push(2'b10, 8'd3);
    bus.cmd_valid = 1'b0;
    check("t2_idle_before_load", busy, 1'b0);
    cycles(1);
    check("t2_in_load_busy", busy, 1'b1);
    check("t2_in_load_pos", pos, 2'b00);
    cycles(37);
    check("t2_end_busy", busy, 1'b0);
    check("t2_end_pos", pos, 2'b10);
    check_drained("t2_pending_events");

    // ---- back-to-back commands during HOLD, FIFO fills ----
    do_reset();
    expect_ev("t3_x_load", 2'b10, 1'b0, 1'b1, 0);
    expect_ev("t3_x_done", 2'b10, 1'b1, 1'b0, 1);
    expect_ev("t3_a_load", 2'b01, 1'b0, 1'b1, 0);
    expect_ev("t3_a_done", 2'b01, 1'b1, 1'b0, 1);
    expect_ev("t3_b_load", 2'b11, 1'b0, 1'b1, 0);
    expect_ev("t3_b_done", 2'b11, 1'b1, 1'b0, 2);
    expect_ev("t3_c_load", 2'b00, 1'b0, 1'b1, 0);
    expect_ev("t3_c_done", 2'b00, 1'b1, 1'b0, 1);
    expect_ev("t3_d_load", 2'b10, 1'b0, 1'b1, 0);
    expect_ev("t3_d_done", 2'b10, 1'b1, 1'b0, 1);
    expect_ev("t3_e_load", 2'b01, 1'b0, 1'b1, 0);
    expect_ev("t3_e_done", 2'b01, 1'b1, 1'b0, 1);
    cycles(1);
    push(2'b10, 8'd1);
    push(2'b01, 8'd1);
    push(2'b11, 8'd2);
    push(2'b00, 8'd0);
    push(2'b10, 8'd1);
    check("t3_ready_low_when_full", bus.cmd_ready, 1'b0);
    push(2'b01, 8'd1);
    bus.cmd_valid = 1'b0;
    cycles(67);
    check("t3_end_busy", busy, 1'b0);
    check("t3_end_pos", pos, 2'b01);
    check_drained("t3_pending_events");

    // ---- autonomous sweep ----
    do_reset();
    expect_ev("t4_step_01", 2'b01, 1'b0, 1'b1, 2);
    expect_ev("t4_step_10", 2'b10, 1'b0, 1'b1, 2);
    expect_ev("t4_step_11", 2'b11, 1'b0, 1'b1, 2);
    expect_ev("t4_step_10b", 2'b10, 1'b0, 1'b1, 2);
    expect_ev("t4_step_01b", 2'b01, 1'b0, 1'b1, 2);
    expect_ev("t4_step_00", 2'b00, 1'b0, 1'b1, 2);
    cycles(1);
    sweep_en = 1'b1;
    cycles(1);
    check("t4_sweep_busy", busy, 1'b1);
    cycles(123);
    sweep_en = 1'b0;
    cycles(1);
    check("t4_stop_busy", busy, 1'b0);
    check("t4_stop_pos", pos, 2'b00);
    cycles(20);
    check("t4_held_pos", pos, 2'b00);
    check_drained("t4_pending_events");

    // ---- command {11,0} interrupts sweep, sweep resumes downward ----
    do_reset();
    expect_ev("t5_step_01", 2'b01, 1'b0, 1'b1, 2);
    expect_ev("t5_step_10", 2'b10, 1'b0, 1'b1, 2);
    expect_ev("t5_load_11", 2'b11, 1'b0, 1'b1, 0);
    expect_ev("t5_done_11", 2'b11, 1'b1, 1'b0, 1);
    expect_ev("t5_resume_10", 2'b10, 1'b0, 1'b1, 2);
    expect_ev("t5_resume_01", 2'b01, 1'b0, 1'b1, 2);
    cycles(1);
    sweep_en = 1'b1;
    cycles(40);
    push(2'b11, 8'd0);
    bus.cmd_valid = 1'b0;
    cycles(53);
    sweep_en = 1'b0;
    cycles(10);
    check("t5_end_busy", busy, 1'b0);
    check("t5_end_pos", pos, 2'b01);
    check_drained("t5_pending_events");

    // ---- reset mid-HOLD with two commands queued ----
    do_reset();
    expect_ev("t6_load", 2'b01, 1'b0, 1'b1, 0);
    cycles(1);
    push(2'b01, 8'd5);
    push(2'b10, 8'd1);
    push(2'b11, 8'd1);
    bus.cmd_valid = 1'b0;
    cycles(21);
    check("t6_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pos", pos, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("t6_rst_cmd_done", cmd_done, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(60);
    check("t6_after_pos", pos, 2'b00);
    check("t6_after_busy", busy, 1'b0);
    check_drained("t6_pending_events");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
